// File: rtl/rs_pkg.sv
// GF(2^8) helpers and shared types for the Reed-Solomon syndrome stage.
// Field: primitive polynomial x^8+x^4+x^3+x^2+1, alpha = 0x02.
package rs_pkg;

    typedef logic [7:0] gf_t;

    // Low byte of the primitive polynomial 0x11D; bit 8 is implied.
    localparam gf_t GF_POLY = 8'h1D;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } syn_state_t;

    // Multiply by alpha: shift left and reduce when bit 7 falls off.
    function automatic gf_t gf_xtime(gf_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

    function automatic gf_t gf_mul(gf_t a, gf_t b);
        gf_t acc;
        gf_t x;
        acc = '0;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = gf_xtime(x);
        end
        return acc;
    endfunction

    function automatic gf_t gf_pow_alpha(int e);
        gf_t acc;
        int  k;
        acc = 8'h01;
        k   = e % 255;
        if (k < 0) k = k + 255;
        for (int i = 0; i < k; i++) acc = gf_xtime(acc);
        return acc;
    endfunction

endpackage

// File: rtl/rs_syn_cell.sv
// One syndrome accumulator S_j with its constant multiplier by alpha^POWER.
// With RS_SYN_ERR_FLAG_EN defined, the next-state value is also exported.
module rs_syn_cell
    import rs_pkg::*;
#(
    parameter int POWER = 1
) (
    input  logic clk,
    input  logic srst,
    input  logic load,
    input  logic step,
    input  gf_t  byte_in,
    output gf_t  s
`ifdef RS_SYN_ERR_FLAG_EN
    ,output gf_t s_next
`endif
);

    localparam gf_t ALPHA_J = gf_pow_alpha(POWER);

    gf_t s_reg;
    gf_t s_nxt;
    gf_t prod;
    gf_t terms [8];

    // Each input bit selects a precomputed column alpha^j * 2^k, so the
    // product reduces to a fixed XOR network with no table.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_col
            localparam gf_t COL = gf_mul(gf_t'(1 << gi), ALPHA_J);
            assign terms[gi] = s_reg[gi] ? COL : 8'h00;
        end
    endgenerate

    always_comb begin
        prod = '0;
        for (int k = 0; k < 8; k++) prod = prod ^ terms[k];
    end

    always_comb begin
        s_nxt = s_reg;
        if (load)      s_nxt = byte_in;
        else if (step) s_nxt = prod ^ byte_in;
    end

    always_ff @(posedge clk) begin
        if (srst) s_reg <= '0;
        else      s_reg <= s_nxt;
    end

    assign s = s_reg;
`ifdef RS_SYN_ERR_FLAG_EN
    assign s_next = s_nxt;
`endif

endmodule

// File: rtl/rs_syndrome_calc.sv
// Streaming RS syndrome generator: Horner evaluation at alpha^1..alpha^TWO_T.
// Optional RS_SYN_ERR_FLAG_EN adds the registered err_detected output.
module rs_syndrome_calc
    import rs_pkg::*;
#(
    parameter int N     = 255,
    parameter int TWO_T = 16
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 in_ready,
    output logic [8*TWO_T-1:0]   syndromes,
    output logic                 syn_valid,
    input  logic                 syn_ack
`ifdef RS_SYN_ERR_FLAG_EN
    ,output logic                err_detected
`endif
);

    localparam logic [7:0] LAST_COUNT = 8'(N - 1);

    syn_state_t state_reg, state_next;
    logic [7:0] count_reg, count_next;
    logic       accept;
    logic       load;
    logic       step;
    logic       last_accept;

`ifdef RS_SYN_ERR_FLAG_EN
    gf_t syn_next [TWO_T];
`endif

    assign accept      = byte_valid && in_ready;
    assign load        = accept && (state_reg == ST_IDLE);
    assign step        = accept && (state_reg == ST_ACCUM);
    assign last_accept = step && (count_reg == LAST_COUNT);

    generate
        for (genvar gi = 0; gi < TWO_T; gi++) begin : g_cell
            rs_syn_cell #(
                .POWER (gi + 1)
            ) u_cell (
                .clk     (clock_in),
                .srst    (reset),
                .load    (load),
                .step    (step),
                .byte_in (byte_in),
                .s       (syndromes[8*gi +: 8])
`ifdef RS_SYN_ERR_FLAG_EN
                ,.s_next (syn_next[gi])
`endif
            );
        end
    endgenerate

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        in_ready   = 1'b1;
        syn_valid  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (byte_valid) begin
                    count_next = 8'd1;
                    state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (byte_valid) begin
                    count_next = count_reg + 8'd1;
                    if (count_reg == LAST_COUNT) state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // Frozen result: input is refused until the consumer acks.
                in_ready  = 1'b0;
                syn_valid = 1'b1;
                if (syn_ack) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

`ifdef RS_SYN_ERR_FLAG_EN
    logic err_reg;
    logic any_next;

    // Reduce the values being loaded on the final accept so the flag is
    // already correct in the first DONE cycle.
    always_comb begin
        any_next = 1'b0;
        for (int j = 0; j < TWO_T; j++) any_next = any_next | (|syn_next[j]);
    end

    always_ff @(posedge clock_in) begin
        if (reset)                                   err_reg <= 1'b0;
        else if (last_accept)                        err_reg <= any_next;
        else if ((state_reg == ST_DONE) && syn_ack)  err_reg <= 1'b0;
    end

    assign err_detected = err_reg;
`endif

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Directed self-checking bench for rs_syndrome_calc (N=255/TWO_T=16 and N=3/TWO_T=2).
module tb_rs_syndrome_calc;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         in_ready;
    logic [127:0] syndromes;
    logic         syn_valid;
    logic         syn_ack;

    logic [7:0]   s_byte_in;
    logic         s_byte_valid;
    logic         s_in_ready;
    logic [15:0]  s_syndromes;
    logic         s_syn_valid;
    logic         s_syn_ack;

`ifdef RS_SYN_ERR_FLAG_EN
    logic         err_detected;
    logic         s_err_detected;
`endif

    int passes = 0;
    int total  = 0;

    rs_syndrome_calc #(.N(255), .TWO_T(16)) dut (
        .clock_in     (clk),
        .reset        (reset),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .in_ready     (in_ready),
        .syndromes    (syndromes),
        .syn_valid    (syn_valid),
        .syn_ack      (syn_ack)
`ifdef RS_SYN_ERR_FLAG_EN
        ,.err_detected(err_detected)
`endif
    );

    rs_syndrome_calc #(.N(3), .TWO_T(2)) dut_small (
        .clock_in     (clk),
        .reset        (reset),
        .byte_in      (s_byte_in),
        .byte_valid   (s_byte_valid),
        .in_ready     (s_in_ready),
        .syndromes    (s_syndromes),
        .syn_valid    (s_syn_valid),
        .syn_ack      (s_syn_ack)
`ifdef RS_SYN_ERR_FLAG_EN
        ,.err_detected(s_err_detected)
`endif
    );

    // alpha^-1 .. alpha^-16, derived by hand by repeated division by alpha.
    logic [7:0] inv_tab [16] = '{8'h8E, 8'h47, 8'hAD, 8'hD8, 8'h6C, 8'h36, 8'h1B, 8'h83,
                                 8'hCF, 8'hE9, 8'hFA, 8'h7D, 8'hB0, 8'h58, 8'h2C, 8'h16};
    logic [127:0] exp_inv;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_big(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_zeros(input int n);
        for (int i = 0; i < n; i++) send_big(8'h00);
    endtask

    task automatic ack_big();
        syn_ack = 1'b1;
        tick();
        syn_ack = 1'b0;
    endtask

    task automatic send_small(input logic [7:0] b);
        s_byte_in    = b;
        s_byte_valid = 1'b1;
        tick();
        s_byte_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; byte_in = '0; byte_valid = 1'b0; syn_ack = 1'b0;
        s_byte_in = '0; s_byte_valid = 1'b0; s_syn_ack = 1'b0;
        for (int j = 0; j < 16; j++) exp_inv[8*j +: 8] = inv_tab[j];
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_in_ready", in_ready, 1);
        chk("rst_syn_valid", syn_valid, 0);
        chk("rst_syndromes", syndromes, 0);
        chk("rst_small_syn", s_syndromes, 0);
`ifdef RS_SYN_ERR_FLAG_EN
        chk("rst_err", err_detected, 0);
`endif

        // All-zero frame
        send_zeros(254);
        chk("zero_pre_last_valid", syn_valid, 0);
        send_big(8'h00);
        chk("zero_syn_valid", syn_valid, 1);
        chk("zero_in_ready", in_ready, 0);
        chk("zero_syndromes", syndromes, 0);
`ifdef RS_SYN_ERR_FLAG_EN
        chk("zero_err", err_detected, 0);
`endif
        ack_big();
        chk("zero_after_ack_valid", syn_valid, 0);
        chk("zero_after_ack_ready", in_ready, 1);

        // Only last symbol nonzero: every S_j equals it
        send_zeros(254);
        send_big(8'h05);
        chk("last05_syn_valid", syn_valid, 1);
        chk("last05_syndromes", syndromes, {16{8'h05}});
`ifdef RS_SYN_ERR_FLAG_EN
        chk("last05_err", err_detected, 1);
`endif
        ack_big();

        // Only first symbol = 0x01: S_j = alpha^-j
        send_big(8'h01);
        send_zeros(254);
        chk("first01_syndromes", syndromes, exp_inv);

        // Hold byte_valid through DONE with a late ack
        byte_in    = 8'hAA;
        byte_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("hold%0d_ready", c), in_ready, 0);
            chk($sformatf("hold%0d_syn", c), syndromes, exp_inv);
            tick();
        end
        syn_ack = 1'b1;
        tick();
        syn_ack    = 1'b0;
        byte_valid = 1'b0;
        chk("hold_ack_valid", syn_valid, 0);
        chk("hold_ack_ready", in_ready, 1);
        chk("hold_ack_kept", syndromes, exp_inv);

        // Next byte starts a new frame (first-symbol load)
        send_big(8'h07);
        chk("newframe_load", syndromes, {16{8'h07}});
        chk("newframe_not_valid", syn_valid, 0);

        // Abort after 100 symbols; reset wins over a simultaneous byte
        for (int i = 0; i < 99; i++) send_big(8'($urandom_range(1, 255)));
        byte_in    = 8'hFF;
        byte_valid = 1'b1;
        reset      = 1'b1;
        tick();
        reset      = 1'b0;
        byte_valid = 1'b0;
        chk("abort_syndromes", syndromes, 0);
        chk("abort_ready", in_ready, 1);
        chk("abort_valid", syn_valid, 0);
        send_zeros(254);
        chk("clean_pre_last_valid", syn_valid, 0);
        send_big(8'h00);
        chk("clean_syn_valid", syn_valid, 1);
        chk("clean_syndromes", syndromes, 0);
`ifdef RS_SYN_ERR_FLAG_EN
        chk("clean_err", err_detected, 0);
`endif
        ack_big();

        // Small DUT: 01,00,00 with gaps -> S1=alpha^2, S2=alpha^4
        send_small(8'h01);
        tick();
        tick();
        chk("small_gap_valid", s_syn_valid, 0);
        chk("small_gap_load", s_syndromes, 16'h0101);
        send_small(8'h00);
        tick();
        chk("small_gap2_valid", s_syn_valid, 0);
        send_small(8'h00);
        chk("small_gap_done", s_syn_valid, 1);
        chk("small_gap_syn", s_syndromes, 16'h1004);
        s_syn_ack = 1'b1;
        tick();
        s_syn_ack = 1'b0;
        chk("small_ack_ready", s_in_ready, 1);

        // 01,02,03 -> S1=0x03, S2=0x1B; ack in first DONE cycle
        send_small(8'h01);
        send_small(8'h02);
        send_small(8'h03);
        chk("small_mix_syn", s_syndromes, 16'h1B03);
`ifdef RS_SYN_ERR_FLAG_EN
        chk("small_mix_err", s_err_detected, 1);
`endif
        s_syn_ack = 1'b1;
        tick();
        s_syn_ack = 1'b0;
        chk("small_done_one_cycle", s_syn_valid, 0);

        // 80,00,00 with ack raised mid-frame (ignored) -> alpha^9, alpha^11
        send_small(8'h80);
        s_syn_ack = 1'b1;
        send_small(8'h00);
        s_syn_ack = 1'b0;
        chk("small_ack_ignored", s_syn_valid, 0);
        send_small(8'h00);
        chk("small_red_valid", s_syn_valid, 1);
        chk("small_red_syn", s_syndromes, 16'hE83A);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
